// File: rtl/mem_copy_engine.sv
// Memory copy engine: copies Len words from SrcAddr to DstAddr through a single
// shared memory port, one word read then written per index, ascending order,
// with wrap-around addressing and a running modulo-2**W checksum of words read.
//
// Handshake: Start is a request that is only looked at in IDLE; there is no
// ready. Busy is high while the copy runs, Done pulses for one cycle at the
// end, and any Start seen outside IDLE (including the DONE cycle) is dropped.
module mem_copy_engine #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [A-1:0] SrcAddr,
  input  logic [A-1:0] DstAddr,
  input  logic [A:0]   Len,
  output logic [A-1:0] MemAddress,
  output logic         MemWriteEn,
  output logic [W-1:0] MemDataIn,
  input  logic [W-1:0] MemDataOut,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] Checksum,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Largest legal word count: the whole memory.
  localparam logic [A:0] MAX_LEN = {1'b1, {A{1'b0}}};

  state_t       state_q, state_d;
  logic [A-1:0] src_q, src_d;
  logic [A-1:0] dst_q, dst_d;
  logic [A:0]   len_q, len_d;
  logic [A:0]   idx_q, idx_d;
  logic [W-1:0] data_q, data_d;
  logic [W-1:0] cks_q, cks_d;
  logic [A:0]   idx_inc;

  assign idx_inc = idx_q + (A+1)'(1);

  // Next-state logic: operand latching, read capture, index advance.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cks_d   = cks_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          src_d   = SrcAddr;
          dst_d   = DstAddr;
          len_d   = (Len > MAX_LEN) ? MAX_LEN : Len;
          idx_d   = '0;
          cks_d   = '0;
          state_d = (Len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        data_d  = MemDataOut;
        cks_d   = cks_q + MemDataOut;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == len_q) ? S_DONE : S_READ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      cks_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cks_q   <= cks_d;
    end
  end

  // Memory port decode from registered state; write strobe is killed by
  // Reset so an aborted copy never writes during the reset cycle.
  always_comb begin
    MemAddress = '0;
    MemWriteEn = 1'b0;
    MemDataIn  = '0;
    case (state_q)
      S_READ: begin
        MemAddress = src_q + idx_q[A-1:0];
      end
      S_WRITE: begin
        MemAddress = dst_q + idx_q[A-1:0];
        MemWriteEn = ~Reset;
        MemDataIn  = data_q;
      end
      default: begin
        MemAddress = '0;
      end
    endcase
  end

  assign Busy      = (state_q == S_READ) || (state_q == S_WRITE);
  assign Done      = (state_q == S_DONE);
  assign Checksum  = cks_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: attached 256x8 memory, reference copy model on a
// shadow array, scoreboard of expected checksum / busy length per copy.
module tb_mem_copy_engine;

  localparam int W = 8;
  localparam int A = 8;

  // ---------------- clock / reset ----------------
  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic [A-1:0] SrcAddr = '0;
  logic [A-1:0] DstAddr = '0;
  logic [A:0]   Len = '0;
  logic [A-1:0] MemAddress;
  logic         MemWriteEn;
  logic [W-1:0] MemDataIn;
  logic [W-1:0] MemDataOut;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Checksum;
  logic [1:0]   dbg_state;

  always #5 Clk = ~Clk;

  mem_copy_engine #(.W(W), .A(A)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Len(Len),
    .MemAddress(MemAddress), .MemWriteEn(MemWriteEn), .MemDataIn(MemDataIn),
    .MemDataOut(MemDataOut), .Busy(Busy), .Done(Done), .Checksum(Checksum),
    .dbg_state(dbg_state)
  );

  // ---------------- attached memory ----------------
  logic [W-1:0] mem [256];
  logic         pl_we = 1'b0;
  logic [A-1:0] pl_addr = '0;
  logic [W-1:0] pl_data = '0;

  assign MemDataOut = mem[MemAddress];

  always @(posedge Clk) begin
    if (MemWriteEn) mem[MemAddress] <= MemDataIn;
    else if (pl_we) mem[pl_addr] <= pl_data;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] ref_mem [256];
  logic [W-1:0] exp_q[$];
  int           exp_busy_q[$];
  int           compares = 0;
  int           mism = 0;
  bit           mon_en = 1'b0;
  int           busy_cnt = 0;

  // Forward copy computed word by word on the shadow array.
  task automatic ref_copy(input logic [7:0] src, input logic [7:0] dst,
                          input logic [8:0] len, output logic [7:0] cks,
                          output int n);
    logic [7:0] v;
    n = (len > 9'd256) ? 256 : int'(len);
    cks = 8'd0;
    for (int i = 0; i < n; i++) begin
      v = ref_mem[(int'(src) + i) % 256];
      cks = cks + v;
      ref_mem[(int'(dst) + i) % 256] = v;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge Clk) begin
    if (mon_en) begin
      if (Reset) begin
        busy_cnt = 0;
      end else begin
        compares++;
        if ((MemWriteEn && !Busy) || (!Busy && (MemAddress != 0 || MemDataIn != 0))
            || (Busy && Done)) begin
          mism++;
          $display("FAIL port_idle: we=%0b busy=%0b done=%0b addr=%0h din=%0h, required idle port outside copy",
                   MemWriteEn, Busy, Done, MemAddress, MemDataIn);
        end
        if (Busy) busy_cnt++;
        if (Done) begin
          compares++;
          if (exp_q.size() == 0) begin
            mism++;
            $display("FAIL unexpected_done: Done=1 with no copy outstanding, required Done=0");
          end else begin
            logic [W-1:0] e;
            int eb;
            e = exp_q.pop_front();
            eb = exp_busy_q.pop_front();
            if (Checksum !== e) begin
              mism++;
              $display("FAIL checksum: got %02h required %02h", Checksum, e);
            end
            compares++;
            if (busy_cnt != eb) begin
              mism++;
              $display("FAIL busy_cycles: got %0d required %0d", busy_cnt, eb);
            end
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge Clk); #1;
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    @(negedge Clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    compares++;
    if (bad != 0) begin
      mism++;
      $display("FAIL mem_%s: %0d words differ (first at %02h: got %02h required %02h)",
               name, bad, first[7:0], mem[first], ref_mem[first]);
    end
  endtask

  task automatic run_copy(input logic [7:0] src, input logic [7:0] dst,
                          input logic [8:0] len, input bit noise, input string name);
    logic [7:0] cks;
    int n, cyc;
    bit seen;
    ref_copy(src, dst, len, cks, n);
    exp_q.push_back(cks);
    exp_busy_q.push_back(2 * n);
    @(negedge Clk); #1;
    Start = 1'b1; SrcAddr = src; DstAddr = dst; Len = len;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 2 * n + 20) begin
      @(negedge Clk);
      cyc++;
      if (Done) seen = 1'b1;
      #1;
      if (noise) begin
        Start = 1'($urandom_range(0, 1));
        SrcAddr = 8'($urandom); DstAddr = 8'($urandom); Len = 9'($urandom);
      end else begin
        Start = 1'b0;
      end
    end
    compares++;
    if (!seen || cyc != 2 * n + 1) begin
      mism++;
      $display("FAIL done_latency_%s: done after %0d cycles (seen=%0b) required %0d",
               name, cyc, seen, 2 * n + 1);
    end
    // A Start left high through DONE must not launch a new copy.
    @(negedge Clk);
    compares++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Checksum !== cks) begin
      mism++;
      $display("FAIL after_done_%s: busy=%0b done=%0b cks=%02h required 0 0 %02h",
               name, Busy, Done, Checksum, cks);
    end
    #1;
    Start = 1'b0;
    check_mem(name);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
    repeat (3) @(negedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    mon_en = 1'b1;
    compares++;
    if (Busy !== 0 || Done !== 0 || MemAddress !== 0 || MemWriteEn !== 0 ||
        MemDataIn !== 0 || Checksum !== 0 || dbg_state !== 0) begin
      mism++;
      $display("FAIL reset_state: busy=%0b done=%0b addr=%0h we=%0b din=%0h cks=%0h st=%0d required all 0",
               Busy, Done, MemAddress, MemWriteEn, MemDataIn, Checksum, dbg_state);
    end

    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
    check_mem("preload");

    // Basic four-word copy.
    poke(8'h10, 8'h01); poke(8'h11, 8'h02); poke(8'h12, 8'h03); poke(8'h13, 8'h04);
    run_copy(8'h10, 8'h80, 9'd4, 1'b0, "basic4");

    // Zero-length copy with Start held through DONE.
    run_copy(8'h33, 8'h44, 9'd0, 1'b1, "len0");

    // Overlapping forward copy across the address wrap.
    poke(8'hFE, 8'hAA); poke(8'hFF, 8'hBB); poke(8'h00, 8'hCC);
    run_copy(8'hFE, 8'hFF, 9'd3, 1'b0, "wrap_overlap");

    // Saturating length, full-memory self copy.
    run_copy(8'h00, 8'h00, 9'h1FF, 1'b0, "sat_full");

    // Exactly the whole memory, overlapping shift with wrap.
    run_copy(8'h05, 8'h07, 9'h100, 1'b1, "len256");

    // Reset during the second WRITE of a four-word copy.
    base = 32;
    @(negedge Clk); #1;
    Start = 1'b1; SrcAddr = 8'(base); DstAddr = 8'h60; Len = 9'd4;
    ref_mem[8'h60] = ref_mem[base];
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk); #1;
      Start = 1'($urandom_range(0, 1));
    end
    Start = 1'b0;
    Reset = 1'b1;
    #1;
    compares++;
    if (MemWriteEn !== 1'b0 || Busy !== 1'b1) begin
      mism++;
      $display("FAIL rst_we_gate: we=%0b busy=%0b required we=0 busy=1", MemWriteEn, Busy);
    end
    @(negedge Clk);
    compares++;
    if (Busy !== 0 || Done !== 0 || Checksum !== 0 || MemAddress !== 0 || dbg_state !== 0) begin
      mism++;
      $display("FAIL rst_abort: busy=%0b done=%0b cks=%02h addr=%0h st=%0d required all 0",
               Busy, Done, Checksum, MemAddress, dbg_state);
    end
    #1 Reset = 1'b0;
    repeat (6) @(negedge Clk);
    check_mem("rst_abort");

    // Randomized copies, some with Start noise while busy.
    for (int t = 0; t < 24; t++) begin
      logic [8:0] l;
      l = (t % 8 == 7) ? 9'($urandom_range(250, 511)) : 9'($urandom_range(0, 40));
      run_copy(8'($urandom), 8'($urandom), l, 1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
    end

    repeat (4) @(negedge Clk);
    compares++;
    if (exp_q.size() != 0) begin
      mism++;
      $display("FAIL leftover: %0d expected Done pulses never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mism);
    $finish;
  end

  // Global time bound.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mism + 1);
    $fatal(1, "watchdog");
  end

endmodule
